// File: rtl/debug_probe_capture_pkg.sv
// Shared types for the debug probe capture block: FSM state encoding and mode codes.
package debug_probe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LIVE  = 2'd1,
    ST_ARMED = 2'd2,
    ST_HELD  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_LIVE    = 2'b00;
  localparam logic [1:0] MODE_FREEZE  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_REPEAT  = 2'b11;

  // Both trigger modes share the upper mode bit.
  function automatic logic is_trig_mode(input logic [1:0] m);
    return m[1];
  endfunction

endpackage

// File: rtl/debug_probe_capture_if.sv
// Probe/overlay bundle for debug_probe_capture; master drives probes and controls, slave is the capture block.
interface debug_probe_capture_if #(
  parameter int NCH  = 8,
  parameter int W    = 16,
  parameter int TS_W = 24
);
  import debug_probe_pkg::*;

  // One extra select bit so out-of-range channel codes (e.g. NCH) are representable.
  localparam int SEL_W = $clog2(NCH + 1);

  logic [NCH*W-1:0] probe_in;
  logic             vsync;
  logic [1:0]       mode;
  logic             arm;
  logic [SEL_W-1:0] trig_sel;
  logic [W-1:0]     trig_mask;
  logic [W-1:0]     trig_value;
  logic [NCH*W-1:0] line_out;
  logic [TS_W-1:0]  trig_ts;
  state_t           state;
  logic             triggered;

  modport master (
    output probe_in, vsync, mode, arm, trig_sel, trig_mask, trig_value,
    input  line_out, trig_ts, state, triggered
  );

  modport slave (
    input  probe_in, vsync, mode, arm, trig_sel, trig_mask, trig_value,
    output line_out, trig_ts, state, triggered
  );

endinterface

// File: rtl/debug_probe_capture_cmp.sv
// Trigger comparator: picks one probe channel and tests it against value under mask.
module probe_trigger_cmp #(
  parameter int NCH   = 8,
  parameter int W     = 16,
  parameter int SEL_W = $clog2(NCH + 1)
) (
  input  logic [NCH*W-1:0] probe,
  input  logic [SEL_W-1:0] sel,
  input  logic [W-1:0]     mask,
  input  logic [W-1:0]     value,
  output logic             hit
);

  logic [W-1:0] chan;

  // Out-of-range selects never hit, even with an all-zero mask.
  always_comb begin
    chan = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SEL_W'(k)) chan = probe[k*W +: W];
    end
    hit = (sel < SEL_W'(NCH)) && (((chan ^ value) & mask) == '0);
  end

endmodule

// File: rtl/debug_probe_capture.sv
// Frame-synchronous capture buffer between core debug probes and the OSD overlay,
// with live, freeze, one-shot and repeating trigger modes plus a trigger timestamp.
module debug_probe_capture
  import debug_probe_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int W       = 16,
  parameter int TS_W    = 24,
  parameter int HOLD_FR = 50
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  debug_probe_capture_if.slave bus
);

  localparam int SEL_W = $clog2(NCH + 1);
  localparam int HC_W  = $clog2(HOLD_FR + 1);

  state_t           cur_state, next_state;
  logic [1:0]       mode_d;
  logic             vsync_d;
  logic [TS_W-1:0]  ts;
  logic [HC_W-1:0]  hold_cnt;
  logic [NCH*W-1:0] line_q;
  logic [TS_W-1:0]  trig_ts_q;
  logic             triggered_q;

  logic vs_rise, hit, mode_chg;
  logic cap_live, cap_trig, hold_dec, hold_clr;

  assign vs_rise  = bus.vsync & ~vsync_d;
  assign mode_chg = (bus.mode != mode_d);

  probe_trigger_cmp #(
    .NCH  (NCH),
    .W    (W),
    .SEL_W(SEL_W)
  ) u_cmp (
    .probe(bus.probe_in),
    .sel  (bus.trig_sel),
    .mask (bus.trig_mask),
    .value(bus.trig_value),
    .hit  (hit)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) cur_state <= ST_IDLE;
    else       cur_state <= next_state;
  end

  // A mode change overrides everything else that cycle, including a pending hit.
  always_comb begin
    next_state = cur_state;
    cap_live   = 1'b0;
    cap_trig   = 1'b0;
    hold_dec   = 1'b0;
    hold_clr   = 1'b0;
    if (mode_chg) begin
      case (bus.mode)
        MODE_LIVE:   next_state = ST_LIVE;
        MODE_FREEZE: next_state = ST_IDLE;
        default:     next_state = ST_ARMED;
      endcase
    end else begin
      case (cur_state)
        ST_IDLE: begin
          if (bus.arm && is_trig_mode(bus.mode)) next_state = ST_ARMED;
        end
        ST_LIVE: begin
          cap_live = vs_rise;
        end
        ST_ARMED: begin
          if (hit) begin
            cap_trig   = 1'b1;
            next_state = ST_HELD;
          end
        end
        ST_HELD: begin
          if (bus.arm) begin
            hold_clr   = 1'b1;
            next_state = ST_ARMED;
          end else if (bus.mode == MODE_REPEAT && vs_rise) begin
            hold_dec = 1'b1;
            if (hold_cnt <= HC_W'(1)) next_state = ST_ARMED;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mode_d      <= MODE_LIVE;
      vsync_d     <= 1'b0;
      ts          <= '0;
      hold_cnt    <= '0;
      line_q      <= '0;
      trig_ts_q   <= '0;
      triggered_q <= 1'b0;
    end else begin
      mode_d      <= bus.mode;
      vsync_d     <= bus.vsync;
      ts          <= ts + 1'b1;
      triggered_q <= cap_trig;
      if (cap_live || cap_trig) line_q <= bus.probe_in;
      if (cap_trig) begin
        trig_ts_q <= ts;
        hold_cnt  <= HC_W'(HOLD_FR);
      end else if (hold_clr) begin
        hold_cnt <= '0;
      end else if (hold_dec) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  assign bus.line_out  = line_q;
  assign bus.trig_ts   = trig_ts_q;
  assign bus.state     = cur_state;
  assign bus.triggered = triggered_q;

endmodule

// File: tb/tb_debug_probe_capture.sv
// Directed self-checking bench for debug_probe_capture with a short hold period (HOLD_FR=2).
module tb_debug_probe_capture;
  import debug_probe_pkg::*;

  localparam int NCH     = 8;
  localparam int W       = 16;
  localparam int TS_W    = 24;
  localparam int HOLD_FR = 2;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  debug_probe_capture_if #(.NCH(NCH), .W(W), .TS_W(TS_W)) bus ();

  debug_probe_capture #(
    .NCH(NCH), .W(W), .TS_W(TS_W), .HOLD_FR(HOLD_FR)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [NCH*W-1:0] probe;
  logic [NCH*W-1:0] exp_line;
  logic [TS_W-1:0]  exp_ts;
  logic [TS_W-1:0]  ts_model;

  assign bus.probe_in = probe;

  // Reference cycle counter: the value the DUT timestamp should hold after each edge.
  always @(posedge clk_sys or posedge reset) begin
    if (reset) ts_model <= '0;
    else       ts_model <= ts_model + 1'b1;
  end

  task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic vsync_pulse;
    bus.vsync = 1'b1;
    tick();
    bus.vsync = 1'b0;
    tick();
  endtask

  task automatic arm_pulse;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [3:0] sel, input logic [15:0] mask, input logic [15:0] value);
    bus.trig_sel   = sel;
    bus.trig_mask  = mask;
    bus.trig_value = value;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    probe     = '0;
    bus.vsync = 1'b0;
    bus.arm   = 1'b0;
    bus.mode  = MODE_FREEZE;
    apply_stimulus(4'd3, 16'hFF00, 16'hAB00);

    #12;
    check_output("rst_line", bus.line_out, '0);
    check_output("rst_ts", bus.trig_ts, '0);
    check_output("rst_state", bus.state, ST_IDLE);
    check_output("rst_trig", bus.triggered, 1'b0);

    @(negedge clk_sys);
    reset = 1'b0;
    tick();
    check_output("freeze_idle", bus.state, ST_IDLE);

    // LIVE: line follows probes only at vsync edges
    probe[0 +: W] = 16'h1234;
    bus.mode = MODE_LIVE;
    tick();
    check_output("live_state", bus.state, ST_LIVE);
    check_output("live_no_edge", bus.line_out, '0);
    exp_line = probe;
    vsync_pulse();
    check_output("live_cap1", bus.line_out, exp_line);
    probe[0 +: W] = 16'h5678;
    tick();
    tick();
    check_output("live_midframe", bus.line_out[0 +: W], 16'h1234);
    vsync_pulse();
    check_output("live_cap2", bus.line_out[0 +: W], 16'h5678);

    // ONESHOT: capture at ts=1000, then held until re-armed
    bus.mode = MODE_ONESHOT;
    tick();
    check_output("os_armed", bus.state, ST_ARMED);
    arm_pulse();
    check_output("os_arm_noop", bus.state, ST_ARMED);
    for (int i = 0; i < 2000 && ts_model != 24'd1000; i++) tick();
    if (ts_model != 24'd1000) check_output("os_ts_wait", ts_model, 24'd1000);
    probe[3*W +: W] = 16'hAB7F;
    exp_line = probe;
    tick();
    check_output("os_state", bus.state, ST_HELD);
    check_output("os_pulse", bus.triggered, 1'b1);
    check_output("os_ts", bus.trig_ts, 24'd1000);
    check_output("os_line", bus.line_out, exp_line);
    probe[3*W +: W] = 16'hAB00;
    tick();
    check_output("os_pulse_end", bus.triggered, 1'b0);
    vsync_pulse();
    check_output("os_hold_state", bus.state, ST_HELD);
    check_output("os_hold_line", bus.line_out, exp_line);
    arm_pulse();
    check_output("os_rearm", bus.state, ST_ARMED);
    check_output("os_rearm_line", bus.line_out, exp_line);
    exp_line = probe;
    exp_ts = ts_model;
    tick();
    check_output("os_recap_line", bus.line_out, exp_line);
    check_output("os_recap_ts", bus.trig_ts, exp_ts);
    check_output("os_recap_pulse", bus.triggered, 1'b1);

    // REPEAT: hold two frames, then re-arm and recapture
    probe[3*W +: W] = 16'h0000;
    bus.mode = MODE_REPEAT;
    tick();
    check_output("rp_armed", bus.state, ST_ARMED);
    probe[3*W +: W] = 16'hAB12;
    exp_line = probe;
    exp_ts = ts_model;
    tick();
    check_output("rp_cap_state", bus.state, ST_HELD);
    check_output("rp_cap_line", bus.line_out, exp_line);
    check_output("rp_cap_ts", bus.trig_ts, exp_ts);
    probe[3*W +: W] = 16'h0000;
    vsync_pulse();
    check_output("rp_hold1", bus.state, ST_HELD);
    vsync_pulse();
    check_output("rp_rearm", bus.state, ST_ARMED);
    probe[3*W +: W] = 16'hABCD;
    exp_line = probe;
    tick();
    check_output("rp_recap_pulse", bus.triggered, 1'b1);
    check_output("rp_recap_line", bus.line_out, exp_line);

    // Collisions: hit with vsync edge, hit with arm, hit with mode change
    probe[3*W +: W] = 16'h0000;
    arm_pulse();
    check_output("col_armed", bus.state, ST_ARMED);
    probe[3*W +: W] = 16'hAB55;
    exp_line = probe;
    bus.vsync = 1'b1;
    tick();
    bus.vsync = 1'b0;
    check_output("col_vs_state", bus.state, ST_HELD);
    check_output("col_vs_pulse", bus.triggered, 1'b1);
    check_output("col_vs_line", bus.line_out, exp_line);
    probe[3*W +: W] = 16'h0000;
    tick();
    vsync_pulse();
    check_output("col_vs_hold_full", bus.state, ST_HELD);
    vsync_pulse();
    check_output("col_vs_rearm", bus.state, ST_ARMED);
    bus.arm = 1'b1;
    probe[3*W +: W] = 16'hAB66;
    exp_line = probe;
    tick();
    bus.arm = 1'b0;
    check_output("col_arm_state", bus.state, ST_HELD);
    check_output("col_arm_line", bus.line_out, exp_line);
    tick();
    check_output("col_arm_consumed", bus.state, ST_HELD);
    probe[3*W +: W] = 16'h0000;
    bus.mode = MODE_ONESHOT;
    tick();
    check_output("col_mode_armed", bus.state, ST_ARMED);
    bus.mode = MODE_LIVE;
    probe[3*W +: W] = 16'hAB77;
    tick();
    check_output("col_mode_state", bus.state, ST_LIVE);
    check_output("col_mode_pulse", bus.triggered, 1'b0);
    check_output("col_mode_line", bus.line_out, exp_line);

    // FREEZE ignores vsync and arm; out-of-range select never triggers
    bus.mode = MODE_FREEZE;
    tick();
    probe[0 +: W] = 16'hFFFF;
    probe[3*W +: W] = 16'hAB00;
    vsync_pulse();
    arm_pulse();
    check_output("frz_state", bus.state, ST_IDLE);
    check_output("frz_line", bus.line_out, exp_line);
    bus.mode = MODE_ONESHOT;
    apply_stimulus(4'(NCH), 16'h0000, 16'h0000);
    tick();
    vsync_pulse();
    for (int i = 0; i < 3; i++) tick();
    check_output("oor_state", bus.state, ST_ARMED);
    check_output("oor_pulse", bus.triggered, 1'b0);
    check_output("oor_line", bus.line_out, exp_line);
    bus.trig_sel = 4'd0;
    exp_line = probe;
    tick();
    check_output("mask0_state", bus.state, ST_HELD);
    check_output("mask0_line", bus.line_out, exp_line);

    // Reset while armed with a live hit
    bus.trig_sel = 4'(NCH);
    arm_pulse();
    check_output("rst2_armed", bus.state, ST_ARMED);
    bus.trig_sel = 4'd0;
    #2;
    reset = 1'b1;
    #1;
    check_output("rst2_line", bus.line_out, '0);
    check_output("rst2_ts", bus.trig_ts, '0);
    check_output("rst2_state", bus.state, ST_IDLE);
    check_output("rst2_trig", bus.triggered, 1'b0);
    tick();
    check_output("rst2_hold_trig", bus.triggered, 1'b0);
    check_output("rst2_hold_state", bus.state, ST_IDLE);
    @(negedge clk_sys);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
